// File: rtl/count_ctrl_pkg.sv
// Shared types for the button-driven counter command sequencer.
// Holds the arbitration FSM states, the repeat direction and a sizing helper.
package count_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_DLY = 2'd1,
    HOLD_RPT = 2'd2,
    LOCK     = 2'd3
  } state_e;

  typedef enum logic {
    UP = 1'b0,
    DN = 1'b1
  } dir_e;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button front end: 2-flop synchroniser, debounce counter and
// registered-previous-level rising-edge detector.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES);

  logic          meta_q;
  logic          sync_q;
  logic          level_q;
  logic          level_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The level flips only on a sample that still differs after it has already
  // differed for DEBOUNCE_CYCLES cycles in a row; any agreeing sample restarts.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop load its pre-edge inputs,
      // which is what turns meta_q/sync_q into a real two-stage synchroniser.
      meta_q  <= raw;
      sync_q  <= meta_q;
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = level_q & ~prev_q;

endmodule

// File: rtl/count_ctrl.sv
// Button command sequencer: debounces up/down/clear, arbitrates between them
// and issues registered single-cycle inc/dec/clr strobes with auto-repeat.
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_up,
  input  logic btn_dn,
  input  logic btn_clr,
  output logic inc,
  output logic dec,
  output logic clr,
  output logic busy
);

  localparam int unsigned TIMER_MAX = max2(REPEAT_DELAY, REPEAT_RATE);
  localparam int unsigned TW        = $clog2(TIMER_MAX);
  localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RPT_LAST = TW'(REPEAT_RATE - 1);

  logic up_lvl, up_rise;
  logic dn_lvl, dn_rise;
  logic clr_lvl, clr_rise;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_up),
    .level (up_lvl),
    .rise  (up_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_dn),
    .level (dn_lvl),
    .rise  (dn_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_clr),
    .level (clr_lvl),
    .rise  (clr_rise)
  );

  state_e        state_q, state_d;
  dir_e          dir_q, dir_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          inc_q, inc_d;
  logic          dec_q, dec_d;
  logic          clr_q, clr_d;
  logic          busy_q;

  logic          act_lvl;
  logic          opp_lvl;
  logic [TW-1:0] timer_last;

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    timer_d    = timer_q;
    inc_d      = 1'b0;
    dec_d      = 1'b0;
    clr_d      = 1'b0;
    act_lvl    = (dir_q == UP) ? up_lvl : dn_lvl;
    opp_lvl    = (dir_q == UP) ? dn_lvl : up_lvl;
    timer_last = (state_q == HOLD_DLY) ? DLY_LAST : RPT_LAST;

    unique case (state_q)
      IDLE: begin
        if (clr_rise) begin
          clr_d   = 1'b1;
          state_d = LOCK;
        end else if (up_rise && dn_rise) begin
          state_d = LOCK;
        end else if (up_rise && !dn_lvl) begin
          inc_d   = 1'b1;
          dir_d   = UP;
          timer_d = '0;
          state_d = HOLD_DLY;
        end else if (dn_rise && !up_lvl) begin
          dec_d   = 1'b1;
          dir_d   = DN;
          timer_d = '0;
          state_d = HOLD_DLY;
        end else if (up_rise || dn_rise) begin
          // A press while the other direction is already held is ambiguous.
          state_d = LOCK;
        end
      end

      HOLD_DLY, HOLD_RPT: begin
        // Release wins over clear, clear over the opposite button, and all
        // three over a repeat strobe falling due in the same cycle.
        if (!act_lvl) begin
          state_d = IDLE;
        end else if (clr_rise) begin
          clr_d   = 1'b1;
          state_d = LOCK;
        end else if (opp_lvl) begin
          state_d = LOCK;
        end else if (timer_q == timer_last) begin
          inc_d   = (dir_q == UP);
          dec_d   = (dir_q == DN);
          timer_d = '0;
          state_d = HOLD_RPT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      LOCK: begin
        if (!up_lvl && !dn_lvl && !clr_lvl) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dir_q   <= UP;
      timer_q <= '0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      timer_q <= timer_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      clr_q   <= clr_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign inc  = inc_q;
  assign dec  = dec_q;
  assign clr  = clr_q;
  assign busy = busy_q;

endmodule
